// File: rtl/receiver_pkg.sv
// Shared SPART constants and receiver state encoding.
// Frame geometry is common to the transmitter and receiver.
package receiver_pkg;

    localparam int unsigned SAMPLES_PER_BIT_DEF = 16;
    localparam int unsigned FRAME_DATA_BITS     = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/receiver_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both stages reset to RESET_VAL so an idle-high line does not look active out of reset.
module rx_synchronizer #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/receiver.sv
// SPART serial receiver: 16x oversampled start/8-data/stop frame, MSB first,
// with data-available, sticky framing-error and sticky overrun status.
module receiver
    import receiver_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
    parameter int unsigned DATA_BITS       = FRAME_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    input  logic                 rxEnable,
    input  logic                 rec_read,
    output logic [DATA_BITS-1:0] rec_buff,
    output logic                 RDA,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int unsigned SW  = $clog2(SAMPLES_PER_BIT);
    localparam int unsigned BCW = $clog2(DATA_BITS);

    localparam logic [SW-1:0]  HALF_LAST = SW'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [SW-1:0]  FULL_LAST = SW'(SAMPLES_PER_BIT - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

    logic rx;

    rx_state_t            state, state_nxt;
    logic [SW-1:0]        sample_cnt, sample_cnt_nxt;
    logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [DATA_BITS-1:0] buff_nxt;
    logic                 rda_nxt, fe_nxt, ov_nxt;

    rx_synchronizer #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (RxD),
        .q   (rx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RX_IDLE;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rec_buff    <= '0;
            RDA         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            sample_cnt  <= sample_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            rec_buff    <= buff_nxt;
            RDA         <= rda_nxt;
            framing_err <= fe_nxt;
            overrun     <= ov_nxt;
        end
    end

    // Status clear by the bus comes first so a same-edge load overrides it.
    always_comb begin
        state_nxt      = state;
        sample_cnt_nxt = sample_cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        buff_nxt       = rec_buff;
        rda_nxt        = RDA;
        fe_nxt         = framing_err;
        ov_nxt         = overrun;

        if (rec_read) begin
            rda_nxt = 1'b0;
            fe_nxt  = 1'b0;
            ov_nxt  = 1'b0;
        end

        if (rxEnable) begin
            case (state)
                RX_IDLE: begin
                    if (!rx) begin
                        state_nxt      = RX_START;
                        sample_cnt_nxt = '0;
                    end
                end
                RX_START: begin
                    sample_cnt_nxt = SW'(sample_cnt + 1'b1);
                    if (sample_cnt == HALF_LAST) begin
                        if (!rx) begin
                            state_nxt      = RX_DATA;
                            sample_cnt_nxt = '0;
                            bit_cnt_nxt    = '0;
                        end else begin
                            state_nxt = RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    sample_cnt_nxt = SW'(sample_cnt + 1'b1);
                    if (sample_cnt == FULL_LAST) begin
                        shift_nxt   = {shift[DATA_BITS-2:0], rx};
                        bit_cnt_nxt = BCW'(bit_cnt + 1'b1);
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    sample_cnt_nxt = SW'(sample_cnt + 1'b1);
                    if (sample_cnt == FULL_LAST) begin
                        if (rx) begin
                            buff_nxt = shift;
                            rda_nxt  = 1'b1;
                            if (RDA && !rec_read) begin
                                ov_nxt = 1'b1;
                            end
                            state_nxt = RX_IDLE;
                        end else begin
                            fe_nxt    = 1'b1;
                            state_nxt = RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx) begin
                        state_nxt = RX_IDLE;
                    end
                end
                default: begin
                    state_nxt = RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Directed plus randomized bench for the SPART receiver against a frame-level model.
module tb_receiver;
    import receiver_pkg::*;

    localparam int unsigned BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic       rxEnable;
    logic       rec_read;
    logic [7:0] rec_buff;
    logic       RDA;
    logic       framing_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    // frame-level reference model
    logic [7:0] m_buff;
    logic       m_rda, m_fe, m_ov;

    int   cyc = 0;
    int   rise_cyc = 0;
    int   start_cyc = 0;
    logic rda_prev = 1'b0;
    logic [1:0] ph = 2'd0;

    receiver dut (
        .clk         (clk),
        .rst         (rst),
        .RxD         (RxD),
        .rxEnable    (rxEnable),
        .rec_read    (rec_read),
        .rec_buff    (rec_buff),
        .RDA         (RDA),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // rxEnable every 4 clk; cycle count and RDA rise time for latency
    always @(negedge clk) begin
        ph       <= ph + 2'd1;
        rxEnable <= (ph == 2'd3);
        cyc      <= cyc + 1;
        rda_prev <= RDA;
        if (RDA && !rda_prev) rise_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        check({tag, ".rec_buff"}, 32'(rec_buff), 32'(m_buff));
        check({tag, ".RDA"}, 32'(RDA), 32'(m_rda));
        check({tag, ".framing_err"}, 32'(framing_err), 32'(m_fe));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
    endtask

    task automatic line(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            RxD = v;
        end
    endtask

    task automatic do_read();
        @(negedge clk);
        rec_read = 1'b1;
        @(negedge clk);
        rec_read = 1'b0;
        m_rda = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] data, input logic stop_bit, input logic read_at_load);
        if (stop_bit) begin
            if (read_at_load) begin
                m_ov = 1'b0;
                m_fe = 1'b0;
            end else if (m_rda) begin
                m_ov = 1'b1;
            end
            m_rda  = 1'b1;
            m_buff = data;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    // Drive start, MSB-first data, stop. With hold_read, rec_read is held high
    // through the stop bit until RDA is seen rising, so it overlaps the load edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic hold_read);
        logic v;
        logic done;
        done = 1'b0;
        for (int b = 0; b < 10; b++) begin
            v = (b == 0) ? 1'b0 : (b == 9) ? stop_bit : data[8-b];
            for (int c = 0; c < int'(BIT_CLK); c++) begin
                @(negedge clk);
                RxD = v;
                if (b == 0 && c == 0) start_cyc = cyc;
                if (hold_read && b == 9 && !done) begin
                    if (c == 14) rec_read = 1'b1;
                    else if (c >= 16 && RDA) begin
                        rec_read = 1'b0;
                        done = 1'b1;
                    end
                end
            end
        end
        rec_read = 1'b0;
        model_frame(data, stop_bit, hold_read);
    endtask

    initial begin
        logic [7:0] d;
        logic       sb;
        int         lat;
        rst = 1'b1; RxD = 1'b1; rec_read = 1'b0; rxEnable = 1'b0;
        m_buff = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset_hold");
        check("reset_state", 32'(dut.state), 32'(RX_IDLE));
        rst = 1'b0;
        line(1'b1, 128);
        check_all("after_reset");

        // basic frame plus latency
        send_frame(8'hA5, 1'b1, 1'b0);
        line(1'b1, 32);
        check_all("frame_a5");
        lat = rise_cyc - start_cyc;
        check("latency_a5", 32'(lat >= 600 && lat <= 625), 32'd1);

        do_read();
        check_all("read_a5");

        // overrun
        send_frame(8'h3C, 1'b1, 1'b0);
        line(1'b1, 64);
        check_all("frame_3c");
        send_frame(8'hC3, 1'b1, 1'b0);
        line(1'b1, 64);
        check_all("overrun_c3");
        do_read();
        check_all("read_c3");

        // framing error, held-low line, then a clean byte
        send_frame(8'h55, 1'b0, 1'b0);
        line(1'b0, 3 * BIT_CLK);
        check_all("framing_55");
        line(1'b1, 64);
        send_frame(8'h0F, 1'b1, 1'b0);
        line(1'b1, 64);
        check_all("after_break_0f");
        do_read();
        check_all("read_0f");

        // short low glitch rejected
        line(1'b0, 16);
        line(1'b1, 128);
        check_all("glitch");
        check("glitch_state", 32'(dut.state), 32'(RX_IDLE));

        // reset in data bit 4 of 0xFF discards the partial byte
        line(1'b0, BIT_CLK);
        line(1'b1, 4 * BIT_CLK + 32);
        rst = 1'b1;
        m_buff = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        line(1'b1, 3);
        check("midframe_reset_state", 32'(dut.state), 32'(RX_IDLE));
        rst = 1'b0;
        line(1'b1, 4 * BIT_CLK);
        check_all("midframe_reset");

        // rec_read coinciding with the load: load wins
        send_frame(8'h81, 1'b1, 1'b1);
        line(1'b1, 32);
        check_all("read_at_load_81");
        send_frame(8'h42, 1'b1, 1'b1);
        line(1'b1, 32);
        check_all("read_at_load_42");
        do_read();

        // randomized frames, stop errors, reads and gaps
        for (int k = 0; k < 12; k++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(4, 0) != 0);
            send_frame(d, sb, 1'b0);
            line(1'b1, int'($urandom_range(3, 1)) * BIT_CLK);
            check_all($sformatf("rand%0d", k));
            if ($urandom_range(1, 0) == 1) begin
                do_read();
                check_all($sformatf("rand_read%0d", k));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
Serial receiver for the SPART. It is the receive-side counterpart of the SPART transmitter and uses the same frame:
- one start bit (0), 8 data bits MSB first, one stop bit (1); idle line is 1.
- RxD is oversampled on a 16x baud enable from the baud generator.
- A completed byte is presented to the bus interface with a data-available flag plus framing/overrun status.

Parameters:
SAMPLES_PER_BIT, 16, rxEnable ticks per bit period; power of two, >= 8
DATA_BITS, 8, data bits per frame; rec_buff width follows

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
RxD  input  1  serial line, asynchronous to clk, idle high
rxEnable  input  1  one-clk pulse at SAMPLES_PER_BIT x baud rate
rec_read  input  1  one-clk pulse: bus has consumed rec_buff
rec_buff  output  8  last correctly framed byte
RDA  output  1  receive data available
framing_err  output  1  sticky: stop bit sampled as 0
overrun  output  1  sticky: byte completed while RDA was already set

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - RDA=0, framing_err=0, overrun=0, rec_buff=8'h00.
  - Synchronizer flops=1; state=IDLE; counters=0.
- RxD passes through a 2-flop synchronizer; all decisions below use the synchronized value rx.
- Every state and counter update happens only on clk edges where rxEnable=1. rec_read acts on any clk edge.
- Counters:
  - sample_cnt: log2(SAMPLES_PER_BIT) bits, wraps at the maximum.
  - bit_cnt: 3 bits.
- IDLE: on a tick with rx=0 -> START, sample_cnt=0.
- START (mid-bit verify): increment sample_cnt each tick. On the tick where sample_cnt==SAMPLES_PER_BIT/2-1:
  - rx=0 -> DATA, sample_cnt=0, bit_cnt=0.
  - rx=1 -> IDLE (glitch rejected; no status change).
- DATA: increment sample_cnt each tick. On the tick where sample_cnt==SAMPLES_PER_BIT-1, i.e. one bit period after the previous sample point:
  - shift <= {shift[6:0], rx}, bit_cnt++.
  - If bit_cnt was 7 -> STOP.
- STOP: on the tick where sample_cnt==SAMPLES_PER_BIT-1, sample rx.
  - rx=1: rec_buff<=shift, RDA<=1 next edge; if RDA was already 1 and rec_read is not high this edge, overrun<=1; -> IDLE.
  - rx=0: framing_err<=1, rec_buff and RDA unchanged -> BREAK.
- BREAK: remain until a tick with rx=1, then -> IDLE. A held-low line therefore never produces repeated frames.
- rec_read:
  - Clears RDA, framing_err and overrun on the next edge.
  - If rec_read coincides with a good-stop load, the load wins: RDA stays 1, rec_buff gets the new byte, overrun is not set.
- Latency: RDA rises one clk after the rxEnable tick that samples the stop bit, roughly 9.5 bit periods after the start-bit falling edge (plus 2 clk sync delay).
- Reset mid-frame: returns to IDLE immediately and discards any partial byte.
- rxEnable held low: all state is frozen.

Decomposition:
- Shared spart package:
  - receiver state encodings IDLE=0, START=1, DATA=2, STOP=3, BREAK=4.
  - SAMPLES_PER_BIT default and the frame bit-count constant (shared with the transmitter).
- One sub-module: rx_synchronizer, a 2-flop synchronizer with async reset to 1, reusable for other async inputs.

Test Plan:
- Stimulus for all cases: rxEnable every 4 clk (bit = 64 clk).
- Frame 0xA5 on RxD -> RDA=1 about 608 clk after the start edge; rec_buff=8'hA5; framing_err=0, overrun=0.
- Then pulse rec_read -> RDA=0 next edge; rec_buff holds 8'hA5.
- Send 0x3C, no read, then 0xC3 -> after the second frame rec_buff=8'hC3, RDA=1, overrun=1. rec_read then clears both flags.
- 0x55 with stop bit driven 0 -> framing_err=1, RDA=0, rec_buff unchanged. Line held low for 3 bit times, then a valid 0x0F -> exactly one byte received, 8'h0F.
- Low glitch of 16 clk (less than half a bit) on an idle line -> no RDA, state back to IDLE.
- Assert rst during data bit 4 of 0xFF, then send 0x81 -> only 8'h81 is delivered. Also: rec_read on the same edge as the 0x81 load -> RDA stays 1, overrun stays 0.
